// File: rtl/alu_regfile_seq.sv
// Operand-fetch / issue / writeback stage in front of ALU64: an 8 x 64-bit register file,
// one instruction per handshake, with ALU64's registered result written back two edges after issue.
module alu_regfile_seq #(
  parameter int NREGS = 8,
  parameter int W     = 64,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_imm_en,
  input  logic [W-1:0]  in_imm,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_op,
  input  logic [W-1:0]  alu_result,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [W-1:0]  wb_data,
  output logic          err,
  input  logic [RW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI = 4'hF;

  // Opcodes ALU64 implements; 9 and 12-14 are reserved and get dropped with an err pulse.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= 4'd8) || (op == 4'd10) || (op == 4'd11);
  endfunction

  // Register 0 is hard-wired to zero on every read port.
  function automatic logic [W-1:0] rf_read(input logic [W-1:0] rf [NREGS],
                                           input logic [RW-1:0] idx);
    return (idx == '0) ? '0 : rf[idx];
  endfunction

  state_t        state_q,  state_d;
  logic [W-1:0]  alu_a_q,  alu_a_d;
  logic [W-1:0]  alu_b_q,  alu_b_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [RW-1:0] rd_q,     rd_d;
  logic          ldi_q,    ldi_d;
  logic [W-1:0]  imm_q,    imm_d;
  logic          err_q,    err_d;
  logic [W-1:0]  regs_q [NREGS];
  logic [W-1:0]  regs_d [NREGS];
  logic [W-1:0]  wb_value;
  logic          accept;

  // Reset gates the handshake so nothing is accepted while rst_n is low.
  assign in_ready = rst_n && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign wb_value = ldi_q ? imm_q : alu_result;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned
    // (which would infer a latch); combinational blocks use blocking '=' throughout.
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    ldi_d    = ldi_q;
    imm_d    = imm_q;
    err_d    = 1'b0;
    regs_d   = regs_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_op == OP_LDI) begin
            rd_d    = in_rd;
            imm_d   = in_imm;
            ldi_d   = 1'b1;
            state_d = S_WB;
          end else if (is_alu_op(in_op)) begin
            alu_a_d  = rf_read(regs_q, in_rs1);
            alu_b_d  = in_imm_en ? in_imm : rf_read(regs_q, in_rs2);
            alu_op_d = in_op;
            rd_d     = in_rd;
            ldi_d    = 1'b0;
            state_d  = S_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (rd_q != '0) regs_d[rd_q] = wb_value;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      ldi_q    <= 1'b0;
      imm_q    <= '0;
      err_q    <= 1'b0;
      // NOTE: the file is reset entry by entry because its post-reset contents are visible on
      // dbg_data and to the first instruction; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      ldi_q    <= ldi_d;
      imm_q    <= imm_d;
      err_q    <= err_d;
      regs_q   <= regs_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign err      = err_q;
  assign wb_valid = (state_q == S_WB);
  assign wb_rd    = rd_q;
  // ALU64's result only exists during WB, so the writeback data is driven combinationally there.
  assign wb_data  = (state_q == S_WB) ? wb_value : '0;
  assign dbg_data = rf_read(regs_q, dbg_addr);

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Bench for alu_regfile_seq: a behavioural ALU64 stub with a registered result, a writeback
// scoreboard fed at issue time, and one task per scenario.
module tb_alu_regfile_seq;

  localparam int W  = 64;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [RW-1:0] in_rd, in_rs1, in_rs2;
  logic          in_imm_en;
  logic [W-1:0]  in_imm;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_result = '0;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic          err;
  logic [RW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [W-1:0]  data;
  } wb_t;

  wb_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  alu_regfile_seq #(.NREGS(8), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU64 stand-in: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SHL 6 SHR 7 SRA 8 MUL 10 ROTL 11 ROTR.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
    int s;
    s = int'(b[5:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << s;
      4'd6:  return a >> s;
      4'd7:  return W'($signed(a) >>> s);
      4'd8:  return a * b;
      4'd10: return (a << s) | (a >> (W - s));
      4'd11: return (a >> s) | (a << (W - s));
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_op);

  // Writeback monitor: every wb_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL wb_unexpected: rd=%0d data=%h with nothing outstanding", wb_rd, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          mismatched++;
          $display("FAIL wb_match: got rd=%0d data=%h, expected rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one instruction, wait (bounded) for in_ready, and return at the negedge after accept.
  task automatic issue(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                       input logic [RW-1:0] rs2, input logic imm_en, input logic [W-1:0] imm,
                       input logic exp_wb, input logic [W-1:0] exp_data);
    int n;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm_en = imm_en; in_imm = imm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 20) begin
      mismatched++;
      $display("FAIL issue_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    if (exp_wb) exp_q.push_back('{rd: rd, data: exp_data});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 20) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d outstanding, in_ready=%b, required 0 and 1",
               exp_q.size(), in_ready);
    end
  endtask

  task automatic read_dbg(input logic [RW-1:0] idx, output logic [W-1:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm_en = 1'b0; in_imm = '0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (in_ready !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || alu_op !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: ready=%b wb_valid=%b err=%b alu_op=%h, required 0 0 0 0",
               in_ready, wb_valid, err, alu_op);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
    // Populate registers, then reset in the middle of an ADD.
    issue(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 64'd11, 1'b1, 64'd11);
    issue(4'hF, 3'd2, 3'd0, 3'd0, 1'b0, 64'd22, 1'b1, 64'd22);
    wait_drain();
    issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 64'd0, 1'b1, 64'd33);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      read_dbg(RW'(i), v);
      compared++;
      if (v !== '0) begin
        mismatched++;
        $display("FAIL reset_reg_r%0d: dbg_data=%h, required 0", i, v);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_after_release: ready=%b wb_valid=%b, required 1 0", in_ready, wb_valid);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] v;
    issue(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 64'd3, 1'b1, 64'd3);
    issue(4'hF, 3'd2, 3'd0, 3'd0, 1'b0, 64'd4, 1'b1, 64'd4);
    wait_drain();
    issue(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    compared++;
    if (wb_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL sub_latency_exec: wb_valid=%b one cycle after accept, required 0", wb_valid);
    end
    @(negedge clk);
    compared++;
    if (wb_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL sub_latency_wb: wb_valid=%b at writeback cycle, required 1", wb_valid);
    end
    @(negedge clk);
    read_dbg(3'd3, v);
    compared++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      mismatched++;
      $display("FAIL sub_r3: dbg_data=%h, required ffffffffffffffff", v);
    end
  endtask

  task automatic test_mul_rotr();
    logic [W-1:0] v;
    issue(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 64'd3000000, 1'b1, 64'd3000000);
    wait_drain();
    issue(4'd8, 3'd4, 3'd1, 3'd0, 1'b1, 64'd2000000, 1'b1, 64'd6000000000000);
    compared++;
    if (alu_a !== 64'd3000000 || alu_b !== 64'd2000000 || alu_op !== 4'd8) begin
      mismatched++;
      $display("FAIL mul_operands: a=%0d b=%0d op=%0d, required 3000000 2000000 8",
               alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    compared++;
    if (alu_a !== 64'd3000000 || alu_b !== 64'd2000000 || alu_op !== 4'd8) begin
      mismatched++;
      $display("FAIL mul_hold_wb: a=%0d b=%0d op=%0d, required 3000000 2000000 8",
               alu_a, alu_b, alu_op);
    end
    wait_drain();
    read_dbg(3'd4, v);
    compared++;
    if (v !== 64'd6000000000000) begin
      mismatched++;
      $display("FAIL mul_r4: dbg_data=%0d, required 6000000000000", v);
    end
    issue(4'd11, 3'd5, 3'd4, 3'd0, 1'b1, 64'd1, 1'b1, 64'd3000000000000);
    wait_drain();
    read_dbg(3'd5, v);
    compared++;
    if (v !== 64'd3000000000000 || alu_a !== 64'd6000000000000 || alu_b !== 64'd1) begin
      mismatched++;
      $display("FAIL rotr_r5: r5=%0d a=%0d b=%0d, required 3000000000000 6000000000000 1",
               v, alu_a, alu_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]    ops  [3] = '{4'd0, 4'd0, 4'd1};
    logic [RW-1:0] rds  [3] = '{3'd2, 3'd3, 3'd4};
    logic [RW-1:0] rs1s [3] = '{3'd1, 3'd2, 3'd3};
    logic [RW-1:0] rs2s [3] = '{3'd0, 3'd0, 3'd1};
    logic          ies  [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0]  imms [3] = '{64'd1, 64'd2, 64'd0};
    logic [W-1:0]  exps [3] = '{64'd101, 64'd103, 64'd3};
    int            acc  [3];
    int            busy, n;
    logic [W-1:0]  v;
    issue(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 64'd100, 1'b1, 64'd100);
    wait_drain();
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      in_op = ops[i]; in_rd = rds[i]; in_rs1 = rs1s[i]; in_rs2 = rs2s[i];
      in_imm_en = ies[i]; in_imm = imms[i]; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 10) begin
        @(negedge clk);
        busy++;
        n++;
      end
      acc[i] = cyc;
      exp_q.push_back('{rd: rds[i], data: exps[i]});
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();
    compared++;
    if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3 || busy !== 4) begin
      mismatched++;
      $display("FAIL b2b_spacing: gaps=%0d,%0d busy=%0d, required 3,3 busy=4",
               acc[1] - acc[0], acc[2] - acc[1], busy);
    end
    for (int i = 0; i < 3; i++) begin
      read_dbg(rds[i], v);
      compared++;
      if (v !== exps[i]) begin
        mismatched++;
        $display("FAIL b2b_reg_r%0d: dbg_data=%0d, required %0d", rds[i], v, exps[i]);
      end
    end
  endtask

  task automatic test_r0_illegal();
    logic [W-1:0] v;
    issue(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 64'h5A, 1'b1, 64'h5A);
    compared++;
    if (wb_valid !== 1'b1 || wb_data !== 64'h5A) begin
      mismatched++;
      $display("FAIL r0_wb: wb_valid=%b wb_data=%h, required 1 5a", wb_valid, wb_data);
    end
    @(negedge clk);
    read_dbg(3'd0, v);
    compared++;
    if (v !== '0) begin
      mismatched++;
      $display("FAIL r0_read: dbg_data=%h, required 0", v);
    end
    issue(4'd9, 3'd2, 3'd1, 3'd1, 1'b0, 64'd0, 1'b0, 64'd0);
    compared++;
    if (err !== 1'b1 || wb_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL illegal_err: err=%b wb_valid=%b, required 1 0", err, wb_valid);
    end
    @(negedge clk);
    read_dbg(3'd2, v);
    compared++;
    if (err !== 1'b0 || in_ready !== 1'b1 || v !== 64'd101) begin
      mismatched++;
      $display("FAIL illegal_after: err=%b ready=%b r2=%0d, required 0 1 101", err, in_ready, v);
    end
  endtask

  task automatic test_reset_exec();
    logic [W-1:0] v;
    issue(4'd0, 3'd6, 3'd1, 3'd0, 1'b1, 64'd5, 1'b1, 64'd105);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    compared++;
    if (alu_a !== '0 || alu_op !== 4'd0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_exec_async: a=%h op=%h ready=%b, required 0 0 0", alu_a, alu_op, in_ready);
    end
    @(negedge clk);
    compared++;
    if (wb_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_exec_nowb: wb_valid=%b, required 0", wb_valid);
    end
    rst_n = 1'b1;
    read_dbg(3'd6, v);
    compared++;
    if (v !== '0) begin
      mismatched++;
      $display("FAIL rst_exec_r6: dbg_data=%0d, required 0", v);
    end
    issue(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 64'd20, 1'b1, 64'd20);
    issue(4'd0, 3'd6, 3'd1, 3'd0, 1'b1, 64'd5, 1'b1, 64'd25);
    wait_drain();
    read_dbg(3'd6, v);
    compared++;
    if (v !== 64'd25) begin
      mismatched++;
      $display("FAIL rst_exec_recover: r6=%0d, required 25", v);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_mul_rotr();
    test_back_to_back();
    test_r0_illegal();
    test_reset_exec();
    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: %0d writebacks never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Operand-fetch, issue and writeback stage directly upstream of ALU64.
- Holds an 8-entry x 64-bit register file and accepts one instruction per valid/ready handshake.
- Drives ALU64 a/b/op, captures ALU64's registered result one clock later, and writes it back to the destination register.
- Bridges a future instruction sequencer to the ALU datapath.

Parameters:
- NREGS, 8, number of 64-bit registers (power of two; index width RW = log2(NREGS))
- W, 64, datapath width; must match ALU64

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept an instruction
- in_op  in  4  ALU64 opcode, or 4'hF = load-immediate
- in_rd  in  RW  destination register index
- in_rs1  in  RW  source A register index
- in_rs2  in  RW  source B register index
- in_imm_en  in  1  1: operand B = in_imm instead of regs[in_rs2]
- in_imm  in  W  immediate value
- alu_a  out  W  operand A to ALU64 (registered)
- alu_b  out  W  operand B to ALU64 (registered)
- alu_op  out  4  opcode to ALU64 (registered)
- alu_result  in  W  ALU64 result; valid one clk edge after alu_a/b/op are stable
- wb_valid  out  1  one-cycle pulse: writeback occurring this cycle
- wb_rd  out  RW  register being written
- wb_data  out  W  value being written
- err  out  1  one-cycle pulse: illegal opcode dropped
- dbg_addr  in  RW  debug read index
- dbg_data  out  W  combinational regs[dbg_addr]

Behaviour:
- Async reset (rst_n low): state=IDLE; all regs, alu_a, alu_b, alu_op, wb_rd, wb_data = 0; wb_valid = err = 0; in_ready = 0 while rst_n low, 1 in the first cycle after release.
- Register 0 always reads 0; writes to it are discarded. wb_valid still pulses, with wb_data = the computed value.
- FSM states: IDLE, EXEC, WB.
- in_ready = (state == IDLE). Accept = in_valid && in_ready at a rising edge.
- IDLE, accept with legal ALU op (0-8, 10, 11):
  - alu_a <= regs[in_rs1]; alu_b <= in_imm_en ? in_imm : regs[in_rs2]; alu_op <= in_op; latch rd.
  - Go to EXEC.
- EXEC (1 cycle): alu_a/b/op held stable; ALU64 samples at the closing edge. Go to WB.
- WB (1 cycle): wb_valid=1, wb_rd=latched rd, wb_data=alu_result. regs[rd] <= alu_result at the closing edge. Go to IDLE.
- Latency: accept edge to wb_valid = 2 cycles. Throughput: 1 instruction per 3 cycles. No pipelining, so no hazards; an instruction sees all prior writebacks.
- Load-immediate (in_op=4'hF): IDLE -> WB directly; wb_data=in_imm; regs[rd] <= in_imm. alu_a/b/op are unchanged. Latency 1 cycle.
- Illegal op (9, 12, 13, 14): accepted (in_ready was 1), err pulses the next cycle, no register write, no wb_valid, state stays IDLE.
- alu_a/b/op hold their last values in IDLE and WB (no spurious toggling).
- in_valid while busy: ignored; the upstream holds the instruction until in_ready.
- Reset asserted mid-instruction (EXEC or WB): the instruction is abandoned, no writeback occurs, and all state returns to reset values immediately.
- Width rules: all arithmetic is done in ALU64; this block only moves W-bit values. No truncation or extension except rs/rd index decode.
- dbg_data reflects a writeback from the cycle after the WB edge.

Test Plan:
- Reset: hold rst_n=0 mid-stream, then release -> all dbg reads 0, in_ready=1, wb_valid=0.
- LDI r1=3, LDI r2=4, then SUB r3=r1-r2 -> wb_valid 2 cycles after the SUB accept, wb_data=64'hFFFFFFFFFFFFFFFF, dbg r3 matches.
- LDI r1=3000000, MUL r4=r1*imm 2000000 (in_imm_en=1) -> r4=6000000000000. Then ROTR r5=r4 by imm 1 -> ALU64 rotate result written.
- Back-to-back in_valid held high for 3 instructions -> in_ready low during EXEC/WB, each accepted exactly once, 3-cycle spacing, results in order.
- Write to r0 via LDI 64'h5A -> wb_valid=1, wb_data=64'h5A, dbg r0 = 0. Op 9 -> err pulse, no wb_valid, registers unchanged.
- Assert rst_n during EXEC of ADD r6 -> no wb_valid, r6=0 after reset, next instruction executes normally.
